// File: rtl/rv32i_pkg.sv
// Shared RV32I definitions: next-PC select encodings, fetch FSM states,
// the canonical NOP word and the base opcode constants used by the decoder.
package rv32i_pkg;

  typedef enum logic [1:0] {
    SEL_SEQ  = 2'd0,
    SEL_BR   = 2'd1,
    SEL_JAL  = 2'd2,
    SEL_JALR = 2'd3
  } next_pc_sel_e;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_VALID = 2'd1,
    ST_TRAP  = 2'd2
  } fetch_state_e;

  // addi x0,x0,0
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

endpackage

// File: rtl/fetch_if.sv
// Instruction-memory read port.
//   master (fetch): drives imem_req/imem_addr, receives imem_rvalid/imem_rdata.
//   slave  (memory): the reverse.
interface fetch_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;

  modport master (output imem_req, imem_addr, input imem_rvalid, imem_rdata);
  modport slave  (input imem_req, imem_addr, output imem_rvalid, imem_rdata);
endinterface

// File: rtl/fetch_next_pc.sv
// next_pc: combinational next-PC selection.
//   pc, next_pc_sel, branch_taken, target_addr in
//   next            : selected next PC (mod 2^32)
//   misaligned_next : next is not word aligned
module next_pc
  import rv32i_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [1:0]  next_pc_sel,
  input  logic        branch_taken,
  input  logic [31:0] target_addr,
  output logic [31:0] next,
  output logic        misaligned_next
);

  logic [31:0] seq;
  assign seq = pc + 32'd4;

  always_comb begin
    next = seq;
    case (next_pc_sel)
      SEL_SEQ:  next = seq;
      SEL_BR:   next = branch_taken ? target_addr : seq;
      SEL_JAL:  next = target_addr;
      SEL_JALR: next = {target_addr[31:1], 1'b0};
      default:  next = seq;
    endcase
  end

  assign misaligned_next = |next[1:0];

endmodule

// File: rtl/fetch.sv
// fetch: RV32I instruction fetch stage.
//   clk, rst (async, active high)
//   imem        : instruction memory read port (fetch_if.master)
//   advance     : core retired current instruction
//   next_pc_sel, branch_taken, target_addr : next-PC control from execute
//   instr, opcode, instr_valid, pc, pc_plus4 : held instruction and its PC
//   misaligned  : sticky misaligned-target flag (FSM parks in TRAP)
module fetch #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  fetch_if.master     imem,
  input  logic        advance,
  input  logic [1:0]  next_pc_sel,
  input  logic        branch_taken,
  input  logic [31:0] target_addr,
  output logic [31:0] instr,
  output logic [6:0]  opcode,
  output logic        instr_valid,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        misaligned
);
  import rv32i_pkg::*;

  fetch_state_e state;
  logic [31:0]  pc_q, instr_q;
  logic         vld_q, req_q, mis_q;
  logic [31:0]  nxt;
  logic         nxt_mis;

  next_pc u_next_pc (
    .pc              (pc_q),
    .next_pc_sel     (next_pc_sel),
    .branch_taken    (branch_taken),
    .target_addr     (target_addr),
    .next            (nxt),
    .misaligned_next (nxt_mis)
  );

  // imem_req is kept as its own register, set exactly when entering FETCH.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_FETCH;
      pc_q    <= RESET_PC;
      instr_q <= NOP_INSTR;
      vld_q   <= 1'b0;
      req_q   <= 1'b1;
      mis_q   <= 1'b0;
    end else begin
      case (state)
        ST_FETCH: if (imem.imem_rvalid) begin
          instr_q <= imem.imem_rdata;
          vld_q   <= 1'b1;
          req_q   <= 1'b0;
          state   <= ST_VALID;
        end
        ST_VALID: if (advance) begin
          // Either way the held instruction is retired; a bad target keeps pc.
          instr_q <= NOP_INSTR;
          vld_q   <= 1'b0;
          if (nxt_mis) begin
            mis_q <= 1'b1;
            state <= ST_TRAP;
          end else begin
            pc_q  <= nxt;
            req_q <= 1'b1;
            state <= ST_FETCH;
          end
        end
        ST_TRAP: ;
        default: begin
          instr_q <= NOP_INSTR;
          vld_q   <= 1'b0;
          req_q   <= 1'b0;
          mis_q   <= 1'b1;
          state   <= ST_TRAP;
        end
      endcase
    end
  end

  assign imem.imem_req  = req_q;
  assign imem.imem_addr = pc_q;
  assign instr          = instr_q;
  assign opcode         = instr_q[6:0];
  assign instr_valid    = vld_q;
  assign pc             = pc_q;
  assign pc_plus4       = pc_q + 32'd4;
  assign misaligned     = mis_q;

endmodule

// File: tb/tb_fetch.sv
module tb_fetch;
  logic        clk = 1'b0;
  logic        rst;
  logic        advance, branch_taken;
  logic [1:0]  next_pc_sel;
  logic [31:0] target_addr;
  logic [31:0] instr, pc, pc_plus4;
  logic [6:0]  opcode;
  logic        instr_valid, misaligned;
  int checks = 0;
  int errors = 0;

  fetch_if bus ();

  fetch #(.RESET_PC(32'h0), .NOP_INSTR(32'h0000_0013)) dut (
    .clk          (clk),
    .rst          (rst),
    .imem         (bus),
    .advance      (advance),
    .next_pc_sel  (next_pc_sel),
    .branch_taken (branch_taken),
    .target_addr  (target_addr),
    .instr        (instr),
    .opcode       (opcode),
    .instr_valid  (instr_valid),
    .pc           (pc),
    .pc_plus4     (pc_plus4),
    .misaligned   (misaligned)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic drive_idle();
    bus.imem_rvalid = 1'b0; bus.imem_rdata = 32'h0;
    advance = 1'b0; next_pc_sel = 2'd0; branch_taken = 1'b0; target_addr = 32'h0;
  endtask

  task automatic do_fetch(input logic [31:0] d);
    bus.imem_rvalid = 1'b1; bus.imem_rdata = d;
    step();
    bus.imem_rvalid = 1'b0; bus.imem_rdata = 32'h0;
  endtask

  task automatic do_adv(input logic [1:0] sel, input logic tk, input logic [31:0] tgt);
    advance = 1'b1; next_pc_sel = sel; branch_taken = tk; target_addr = tgt;
    step();
    drive_idle();
  endtask

  task automatic test_reset();
    rst = 1'b1; drive_idle();
    step(); step();
    checks++; if (pc !== 32'h0) begin errors++; $display("FAIL rst_pc got %h want %h", pc, 32'h0); end
    checks++; if (instr !== 32'h13) begin errors++; $display("FAIL rst_instr got %h want %h", instr, 32'h13); end
    checks++; if (opcode !== 7'b0010011) begin errors++; $display("FAIL rst_opcode got %b want %b", opcode, 7'b0010011); end
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b want 0", instr_valid); end
    checks++; if (misaligned !== 1'b0) begin errors++; $display("FAIL rst_mis got %b want 0", misaligned); end
    rst = 1'b0; #1;
    checks++; if (bus.imem_req !== 1'b1) begin errors++; $display("FAIL rst_req got %b want 1", bus.imem_req); end
  endtask

  task automatic test_zero_wait();
    do_fetch(32'h0050_0093);
    checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL zw_valid got %b want 1", instr_valid); end
    checks++; if (instr !== 32'h0050_0093) begin errors++; $display("FAIL zw_instr got %h want %h", instr, 32'h0050_0093); end
    checks++; if (opcode !== 7'b0010011) begin errors++; $display("FAIL zw_opcode got %b want %b", opcode, 7'b0010011); end
    checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL zw_req_low got %b want 0", bus.imem_req); end
    do_adv(2'd0, 1'b0, 32'h0);
    checks++; if (bus.imem_addr !== 32'h4) begin errors++; $display("FAIL zw_next_addr got %h want %h", bus.imem_addr, 32'h4); end
    checks++; if (bus.imem_req !== 1'b1) begin errors++; $display("FAIL zw_next_req got %b want 1", bus.imem_req); end
    checks++; if (instr !== 32'h13 || instr_valid !== 1'b0) begin errors++; $display("FAIL zw_retire got %h/%b want 00000013/0", instr, instr_valid); end
  endtask

  task automatic test_wait_states();
    for (int i = 0; i < 3; i++) begin
      checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h4 || instr_valid !== 1'b0) begin
        errors++; $display("FAIL ws_stall%0d got req=%b addr=%h vld=%b want 1/4/0", i, bus.imem_req, bus.imem_addr, instr_valid); end
      step();
    end
    checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h4) begin errors++; $display("FAIL ws_4th got req=%b addr=%h want 1/4", bus.imem_req, bus.imem_addr); end
    do_fetch(32'h0000_0463);
    checks++; if (instr !== 32'h0000_0463 || instr_valid !== 1'b1) begin errors++; $display("FAIL ws_latch got %h/%b want 00000463/1", instr, instr_valid); end
    checks++; if (opcode !== 7'b1100011) begin errors++; $display("FAIL ws_opcode got %b want %b", opcode, 7'b1100011); end
    // rvalid in VALID must not overwrite the held word
    bus.imem_rvalid = 1'b1; bus.imem_rdata = 32'hDEAD_BEEF; step(); bus.imem_rvalid = 1'b0;
    checks++; if (instr !== 32'h0000_0463) begin errors++; $display("FAIL ws_ignore_rvalid got %h want 00000463", instr); end
    do_adv(2'd0, 1'b0, 32'h0);
    checks++; if (pc !== 32'h8) begin errors++; $display("FAIL ws_next got %h want 8", pc); end
  endtask

  task automatic test_branch();
    do_fetch(32'h0000_0463);
    do_adv(2'd1, 1'b0, 32'h40);
    checks++; if (bus.imem_addr !== 32'hC) begin errors++; $display("FAIL br_not_taken got %h want c", bus.imem_addr); end
    // advance while still fetching is ignored
    advance = 1'b1; step(); advance = 1'b0;
    checks++; if (pc !== 32'hC || bus.imem_req !== 1'b1) begin errors++; $display("FAIL br_adv_ignored got %h/%b want c/1", pc, bus.imem_req); end
    do_fetch(32'h0000_006F);
    do_adv(2'd2, 1'b0, 32'h8);
    checks++; if (pc !== 32'h8) begin errors++; $display("FAIL br_jal_back got %h want 8", pc); end
    do_fetch(32'h0000_0463);
    do_adv(2'd1, 1'b1, 32'h40);
    checks++; if (bus.imem_addr !== 32'h40) begin errors++; $display("FAIL br_taken got %h want 40", bus.imem_addr); end
  endtask

  task automatic test_jalr();
    do_fetch(32'h0000_0067);
    do_adv(2'd3, 1'b0, 32'h101);
    checks++; if (pc !== 32'h100) begin errors++; $display("FAIL jalr_pc got %h want 100", pc); end
    checks++; if (misaligned !== 1'b0 || bus.imem_req !== 1'b1) begin errors++; $display("FAIL jalr_notrap got %b/%b want 0/1", misaligned, bus.imem_req); end
  endtask

  task automatic test_wrap();
    do_fetch(32'h0000_006F);
    do_adv(2'd2, 1'b0, 32'hFFFF_FFFC);
    checks++; if (pc !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_pc got %h want fffffffc", pc); end
    do_fetch(32'h0000_0013);
    checks++; if (pc_plus4 !== 32'h0) begin errors++; $display("FAIL wrap_plus4 got %h want 0", pc_plus4); end
    do_adv(2'd0, 1'b0, 32'h0);
    checks++; if (bus.imem_addr !== 32'h0 || bus.imem_req !== 1'b1) begin errors++; $display("FAIL wrap_addr got %h/%b want 0/1", bus.imem_addr, bus.imem_req); end
  endtask

  task automatic test_misaligned();
    do_fetch(32'h0000_006F);
    do_adv(2'd2, 1'b0, 32'h8);
    do_fetch(32'h0000_006F);
    do_adv(2'd2, 1'b0, 32'h102);
    checks++; if (misaligned !== 1'b1) begin errors++; $display("FAIL mis_flag got %b want 1", misaligned); end
    checks++; if (pc !== 32'h8) begin errors++; $display("FAIL mis_pc got %h want 8", pc); end
    checks++; if (bus.imem_req !== 1'b0 || instr_valid !== 1'b0 || instr !== 32'h13) begin
      errors++; $display("FAIL mis_outs got req=%b vld=%b instr=%h want 0/0/00000013", bus.imem_req, instr_valid, instr); end
    bus.imem_rvalid = 1'b1; bus.imem_rdata = 32'h0050_0093; advance = 1'b1;
    step(); step(); step();
    drive_idle();
    checks++; if (bus.imem_req !== 1'b0 || pc !== 32'h8 || misaligned !== 1'b1 || instr_valid !== 1'b0) begin
      errors++; $display("FAIL mis_sticky got req=%b pc=%h mis=%b vld=%b want 0/8/1/0", bus.imem_req, pc, misaligned, instr_valid); end
  endtask

  task automatic test_reset_mid_fetch();
    rst = 1'b1; step(); rst = 1'b0; #1;
    checks++; if (misaligned !== 1'b0 || bus.imem_req !== 1'b1 || pc !== 32'h0) begin
      errors++; $display("FAIL rmf_trap_exit got mis=%b req=%b pc=%h want 0/1/0", misaligned, bus.imem_req, pc); end
    step();
    do_fetch(32'h0050_0093);
    do_adv(2'd0, 1'b0, 32'h0);
    step(); step();
    checks++; if (pc !== 32'h4 || bus.imem_req !== 1'b1) begin errors++; $display("FAIL rmf_stalled got %h/%b want 4/1", pc, bus.imem_req); end
    rst = 1'b1; bus.imem_rvalid = 1'b1; bus.imem_rdata = 32'hDEAD_BEEF; #1;
    checks++; if (pc !== 32'h0) begin errors++; $display("FAIL rmf_async_pc got %h want 0", pc); end
    step(); step();
    bus.imem_rvalid = 1'b0; bus.imem_rdata = 32'h0;
    rst = 1'b0; #1;
    checks++; if (instr !== 32'h13 || instr_valid !== 1'b0) begin errors++; $display("FAIL rmf_instr got %h/%b want 00000013/0", instr, instr_valid); end
    checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0) begin errors++; $display("FAIL rmf_req got %b/%h want 1/0", bus.imem_req, bus.imem_addr); end
    step();
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL rmf_no_spurious got %b want 0", instr_valid); end
    do_fetch(32'h0010_0113);
    checks++; if (instr !== 32'h0010_0113 || instr_valid !== 1'b1) begin errors++; $display("FAIL rmf_restart got %h/%b want 00100113/1", instr, instr_valid); end
    do_adv(2'd0, 1'b0, 32'h0);
    checks++; if (bus.imem_addr !== 32'h4) begin errors++; $display("FAIL rmf_next got %h want 4", bus.imem_addr); end
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_wait_states();
    test_branch();
    test_jalr();
    test_wrap();
    test_misaligned();
    test_reset_mid_fetch();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
